// File: rtl/serial_el_rx.sv
// Receiver for the single-wire element stream: start, d0..d3 (LSB first), even parity, stop.
// Oversamples on clk, checks framing and parity, and counts good elements.
module serial_el_rx #(
  parameter int unsigned BIT_TICKS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] el,
  output logic [3:0] nom,
  output logic [1:0] bit_idx,
  output logic       el_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHi} state_e;

  localparam logic [CNT_W-1:0] HalfTick = CNT_W'(BIT_TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] FullTick = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       bit_q, bit_d;
  logic [3:0]       shift_q, shift_d;
  logic [3:0]       el_q, el_d;
  logic [3:0]       nom_q, nom_d;
  logic             par_ok_q, par_ok_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta, rxs;

  // Synchronizer resets to the idle-line level so reset release never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      el_q     <= '0;
      nom_q    <= '0;
      par_ok_q <= 1'b0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      el_q     <= el_d;
      nom_q    <= nom_d;
      par_ok_q <= par_ok_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntOne;
    bit_d    = bit_q;
    shift_d  = shift_q;
    el_d     = el_q;
    nom_d    = nom_q;
    par_ok_d = par_ok_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfTick) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = 2'd0;
          end
        end
      end
      // From here on the counter is aligned to bit centres
      StData: begin
        if (cnt_q == FullTick) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 2'd1;
          if (bit_q == 2'd3) state_d = StParity;
        end
      end
      StParity: begin
        if (cnt_q == FullTick) begin
          cnt_d    = '0;
          par_ok_d = (rxs == ^shift_q);
          state_d  = StStop;
        end
      end
      StStop: begin
        if (cnt_q == FullTick) begin
          cnt_d = '0;
          if (!rxs) begin
            ferr_d  = 1'b1;
            state_d = StWaitHi;
          end else begin
            state_d = StIdle;
            if (par_ok_q) begin
              el_d    = shift_q;
              nom_d   = nom_q + 4'd1;
              valid_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end
        end
      end
      StWaitHi: begin
        cnt_d = '0;
        if (rxs) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign el         = el_q;
  assign nom        = nom_q;
  assign bit_idx    = bit_q;
  assign el_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != StIdle);

endmodule
